// File: rtl/core_pkg.sv
// Shared encodings for the memory-access path: access sizes and MEM-stage FSM states.
// The decode stage and the data memory model use the same definitions.
package core_pkg;

   localparam logic [1:0] MT_B = 2'b00;
   localparam logic [1:0] MT_H = 2'b01;
   localparam logic [1:0] MT_W = 2'b10;
   localparam logic [1:0] MT_D = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_e;

   // Byte-lane mask of an access at lane 0.
   function automatic logic [7:0] size_mask(input logic [1:0] mem_type);
      case (mem_type)
         MT_B:    return 8'h01;
         MT_H:    return 8'h03;
         MT_W:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic [63:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/load_align.sv
// Extracts the addressed bytes from a 64-bit read beat and sign- or zero-extends them.
module load_align
   import core_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  offset,
   input  logic [1:0]  mem_type,
   input  logic        is_unsigned,
   output logic [63:0] load_data
);

   logic [63:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   // A double is only legal at offset 0, so the shifted beat equals the raw beat.
   always_comb begin
      load_data = shifted;
      case (mem_type)
         MT_B: load_data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
         MT_H: load_data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
         MT_W: load_data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on the req/ack port, stalls upstream while
// an access is outstanding (bounded by TIMEOUT), and registers results into MEM/WB.
//
// state   | meaning
// ST_IDLE | no access outstanding; zero-wait accesses complete here
// ST_BUSY | request held, counting wait cycles until ack or timeout
module mem_stage
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        RegWriteM,
   input  logic        MemToRegM,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic        Mem_ReadM,
   input  logic [1:0]  MemTypeM,
   input  logic [4:0]  RD_M,
   input  logic [63:0] ALU_ResultM,
   input  logic [63:0] WriteDataM,
   mem_stage_if.master dmem,
   output logic        stall_M,
   output logic        RegWriteW,
   output logic        MemToRegW,
   output logic [4:0]  RD_W,
   output logic [63:0] ALU_ResultW,
   output logic [63:0] ReadDataW,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   mem_state_e  state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        is_mem, misaligned, access, timed_out, done, req_c;
   logic [2:0]  offset;
   logic [63:0] load_data;

   assign is_mem = MemReadM | MemWriteM;
   assign offset = ALU_ResultM[2:0];

   always_comb begin
      misaligned = 1'b0;
      case (MemTypeM)
         MT_H:    misaligned = offset[0];
         MT_W:    misaligned = |offset[1:0];
         MT_D:    misaligned = |offset;
         default: misaligned = 1'b0;
      endcase
   end

   assign access = is_mem & ~misaligned;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Ack wins over a timeout landing in the same cycle.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      req_c      = access;
      timed_out  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access && !dmem.dmem_ack) begin
               state_d    = ST_BUSY;
               wait_cnt_d = 8'd1;
            end
         end
         ST_BUSY: begin
            req_c = 1'b1;
            if (dmem.dmem_ack) begin
               state_d    = ST_IDLE;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == TIMEOUT_C) begin
               state_d    = ST_IDLE;
               wait_cnt_d = 8'd0;
               timed_out  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   assign done    = dmem.dmem_ack | timed_out;
   assign stall_M = access & ~done;

   assign dmem.dmem_req   = req_c;
   assign dmem.dmem_we    = MemWriteM;
   assign dmem.dmem_addr  = {ALU_ResultM[63:3], 3'b000};
   assign dmem.dmem_wdata = WriteDataM << {offset, 3'b000};
   assign dmem.dmem_wstrb = MemWriteM ? (size_mask(MemTypeM) << offset) : 8'h00;

   load_align u_load_align (
      .rdata       (dmem.dmem_rdata),
      .offset      (offset),
      .mem_type    (MemTypeM),
      .is_unsigned (Mem_ReadM),
      .load_data   (load_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         RegWriteW    <= 1'b0;
         MemToRegW    <= 1'b0;
         RD_W         <= 5'd0;
         ALU_ResultW  <= 64'd0;
         ReadDataW    <= 64'd0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else if (stall_M) begin
         RegWriteW    <= 1'b0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         RegWriteW    <= RegWriteM & ~(is_mem & misaligned) & ~timed_out;
         MemToRegW    <= MemToRegM;
         RD_W         <= RD_M;
         ALU_ResultW  <= ALU_ResultM;
         ReadDataW    <= load_data;
         misalign_err <= is_mem & misaligned;
         bus_err      <= timed_out;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver pushes expected MEM/WB contents to a scoreboard,
// monitor pops and compares whenever an instruction completes.
module tb_mem_stage;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        RegWriteM, MemToRegM, MemWriteM, MemReadM, Mem_ReadM;
   logic [1:0]  MemTypeM;
   logic [4:0]  RD_M;
   logic [63:0] ALU_ResultM, WriteDataM;
   logic        stall_M, RegWriteW, MemToRegW, misalign_err, bus_err;
   logic [4:0]  RD_W;
   logic [63:0] ALU_ResultW, ReadDataW;

   mem_stage_if mif ();

   mem_stage #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .RegWriteM    (RegWriteM),
      .MemToRegM    (MemToRegM),
      .MemWriteM    (MemWriteM),
      .MemReadM     (MemReadM),
      .Mem_ReadM    (Mem_ReadM),
      .MemTypeM     (MemTypeM),
      .RD_M         (RD_M),
      .ALU_ResultM  (ALU_ResultM),
      .WriteDataM   (WriteDataM),
      .dmem         (mif.master),
      .stall_M      (stall_M),
      .RegWriteW    (RegWriteW),
      .MemToRegW    (MemToRegW),
      .RD_W         (RD_W),
      .ALU_ResultW  (ALU_ResultW),
      .ReadDataW    (ReadDataW),
      .misalign_err (misalign_err),
      .bus_err      (bus_err)
   );

   always #5 clk = ~clk;

   // Memory model: ack after ack_delay stalled request cycles; -1 never acks.
   int          ack_delay = -1;
   int          req_cnt = 0;
   logic        force_ack = 1'b0;
   logic [63:0] mem_rdata = 64'd0;

   always @(posedge clk) begin
      if (mif.dmem_req && stall_M) req_cnt <= req_cnt + 1;
      else req_cnt <= 0;
   end

   assign mif.dmem_ack   = force_ack | (mif.dmem_req && (ack_delay >= 0) && (req_cnt == ack_delay));
   assign mif.dmem_rdata = mem_rdata;

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [4:0]  rd;
      logic [63:0] alu;
      logic        chk_rd;
      logic [63:0] rdw;
      logic        merr;
      logic        berr;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   logic issue_valid = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: an instruction completes on the edge following a non-stalled cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (issue_valid && !stall_M) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
               e = sb.pop_front();
               chk({e.tag, "_regwrite"}, 64'(RegWriteW), 64'(e.rw));
               chk({e.tag, "_memtoreg"}, 64'(MemToRegW), 64'(e.m2r));
               chk({e.tag, "_rd"},       64'(RD_W),      64'(e.rd));
               chk({e.tag, "_alu"},      ALU_ResultW,    e.alu);
               chk({e.tag, "_merr"},     64'(misalign_err), 64'(e.merr));
               chk({e.tag, "_berr"},     64'(bus_err),   64'(e.berr));
               if (e.chk_rd) chk({e.tag, "_rdata"}, ReadDataW, e.rdw);
            end
         end
      end
   end

   task automatic issue(
      input logic rd_i, wr_i, uns_i, rw_i, m2r_i,
      input logic [1:0] mt_i, input logic [4:0] rdst,
      input logic [63:0] addr_i, wd_i, rdata_i,
      input int delay_i, exp_stall,
      input logic exp_req, input logic [7:0] exp_strb, input logic [63:0] exp_wd,
      input logic exp_rw, chk_rd, input logic [63:0] exp_rdw,
      input logic exp_merr, exp_berr, input string tag);
      int   stalls = 0;
      logic req_seen = 1'b0;
      logic fin = 1'b0;
      logic st;
      MemReadM    = rd_i;
      MemWriteM   = wr_i;
      Mem_ReadM   = uns_i;
      RegWriteM   = rw_i;
      MemToRegM   = m2r_i;
      MemTypeM    = mt_i;
      RD_M        = rdst;
      ALU_ResultM = addr_i;
      WriteDataM  = wd_i;
      mem_rdata   = rdata_i;
      ack_delay   = delay_i;
      issue_valid = 1'b1;
      sb.push_back('{exp_rw, m2r_i, rdst, addr_i, chk_rd, exp_rdw, exp_merr, exp_berr, tag});
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         st = stall_M;
         if (mif.dmem_req) req_seen = 1'b1;
         if (c == 0 && exp_req) begin
            chk({tag, "_addr"},  mif.dmem_addr, {addr_i[63:3], 3'b000});
            chk({tag, "_we"},    64'(mif.dmem_we), 64'(wr_i));
            chk({tag, "_wstrb"}, 64'(mif.dmem_wstrb), 64'(exp_strb));
            chk({tag, "_wdata"}, mif.dmem_wdata, exp_wd);
         end
         if (st && stalls >= 1) chk({tag, "_bubble"}, 64'(RegWriteW), 64'd0);
         if (st) stalls++;
         @(posedge clk);
         #1;
         if (!st) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) begin
         total++;
         bad++;
         $display("FAIL %s_complete actual=stuck required=done", tag);
      end
      chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
      chk({tag, "_req"},    64'(req_seen), 64'(exp_req));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      {RegWriteM, MemToRegM, MemWriteM, MemReadM, Mem_ReadM} = 5'b0;
      MemTypeM = MT_B; RD_M = 5'd0; ALU_ResultM = 64'd0; WriteDataM = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_regwrite", 64'(RegWriteW), 64'd0);
      chk("rst_rd",       64'(RD_W), 64'd0);
      chk("rst_alu",      ALU_ResultW, 64'd0);
      chk("rst_rdata",    ReadDataW, 64'd0);
      chk("rst_errs",     64'({misalign_err, bus_err, MemToRegW}), 64'd0);
      chk("rst_req",      64'(mif.dmem_req), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      //    rd wr un rw m2 mt    rd  addr           wdata                   rdata                   dly st req strb   exp_wdata               erw chk exp_rdata               me be tag
      issue(0, 1, 0, 0, 0, MT_D, 3,  64'h100, 64'h1122334455667788, 64'h0,                 0, 0, 1, 8'hFF, 64'h1122334455667788, 0, 0, 64'h0,                 0, 0, "sd");
      issue(1, 0, 0, 1, 1, MT_B, 7,  64'h103, 64'h0,                64'h1122334455667788,  2, 2, 1, 8'h00, 64'h0,                1, 1, 64'h55,                0, 0, "lb");
      issue(1, 0, 1, 1, 1, MT_H, 8,  64'h106, 64'h0,                64'h1122334455667788,  1, 1, 1, 8'h00, 64'h0,                1, 1, 64'h1122,              0, 0, "lhu");
      issue(1, 0, 0, 1, 1, MT_H, 9,  64'h106, 64'h0,                64'h1122334455667788,  0, 0, 1, 8'h00, 64'h0,                1, 1, 64'h1122,              0, 0, "lh");
      issue(1, 0, 0, 1, 1, MT_W, 10, 64'h104, 64'h0,                64'h8000000100000000,  3, 3, 1, 8'h00, 64'h0,                1, 1, 64'hFFFFFFFF80000001,  0, 0, "lw");
      issue(1, 0, 1, 1, 1, MT_W, 11, 64'h104, 64'h0,                64'h8000000100000000,  0, 0, 1, 8'h00, 64'h0,                1, 1, 64'h0000000080000001,  0, 0, "lwu");
      issue(1, 0, 0, 1, 1, MT_B, 12, 64'h107, 64'h0,                64'h8100000000000000,  1, 1, 1, 8'h00, 64'h0,                1, 1, 64'hFFFFFFFFFFFFFF81,  0, 0, "lb_neg");
      issue(1, 0, 1, 1, 1, MT_B, 13, 64'h107, 64'h0,                64'h8100000000000000,  0, 0, 1, 8'h00, 64'h0,                1, 1, 64'h81,                0, 0, "lbu");
      issue(0, 1, 0, 0, 0, MT_B, 0,  64'h105, 64'hAB,               64'h0,                 1, 1, 1, 8'h20, 64'h0000AB0000000000, 0, 0, 64'h0,                 0, 0, "sb");
      issue(0, 1, 0, 0, 0, MT_H, 0,  64'h10A, 64'hBEEF,             64'h0,                 0, 0, 1, 8'h0C, 64'h00000000BEEF0000, 0, 0, 64'h0,                 0, 0, "sh");
      issue(1, 0, 0, 1, 1, MT_D, 14, 64'h108, 64'h0,                64'hDEADBEEFCAFEF00D,  0, 0, 1, 8'h00, 64'h0,                1, 1, 64'hDEADBEEFCAFEF00D,  0, 0, "ld");
      issue(1, 0, 0, 1, 1, MT_W, 15, 64'h102, 64'h0,                64'h0,                 0, 0, 0, 8'h00, 64'h0,                0, 0, 64'h0,                 1, 0, "lw_mis");
      issue(1, 0, 0, 1, 1, MT_D, 16, 64'h200, 64'h0,                64'h0,                -1, 4, 1, 8'h00, 64'h0,                0, 0, 64'h0,                 0, 1, "ld_tmo");
      issue(0, 0, 0, 1, 0, MT_B, 5,  64'h1234, 64'h0,               64'h0,                 0, 0, 0, 8'h00, 64'h0,                1, 0, 64'h0,                 0, 0, "alu");
      force_ack = 1'b1;
      issue(0, 0, 0, 1, 0, MT_B, 6,  64'h55AA, 64'h0,               64'h0,                 0, 0, 0, 8'h00, 64'h0,                1, 0, 64'h0,                 0, 0, "alu_idle_ack");
      force_ack = 1'b0;

      issue_valid = 1'b0;
      {RegWriteM, MemToRegM, MemWriteM, MemReadM, Mem_ReadM} = 5'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
